// File: rtl/shift_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : shift_arbiter_if
// Brief   : Request/response bundle between two requesters and the shared
//           shift unit. The arbiter takes the slave side.
// Revision: 1.0 - initial release
// ============================================================================
interface shift_arbiter_if;
    // requester 0
    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_in;
    logic [4:0]  req0_amount;
    logic        req0_right;
    logic        req0_arith;
    // requester 1
    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_in;
    logic [4:0]  req1_amount;
    logic        req1_right;
    logic        req1_arith;
    // responses
    logic        resp0_valid;
    logic        resp1_valid;
    logic        resp0_ready;
    logic        resp1_ready;
    logic [31:0] resp_data;
    logic        resp_err;

    modport slave (
        input  req0_valid, req0_in, req0_amount, req0_right, req0_arith,
        input  req1_valid, req1_in, req1_amount, req1_right, req1_arith,
        input  resp0_ready, resp1_ready,
        output req0_ready, req1_ready,
        output resp0_valid, resp1_valid, resp_data, resp_err
    );

    modport master (
        output req0_valid, req0_in, req0_amount, req0_right, req0_arith,
        output req1_valid, req1_in, req1_amount, req1_right, req1_arith,
        output resp0_ready, resp1_ready,
        input  req0_ready, req1_ready,
        input  resp0_valid, resp1_valid, resp_data, resp_err
    );
endinterface
`default_nettype wire

// File: rtl/shift_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : shift_arbiter
// Brief   : Two requesters share one 32-bit barrel shifter. A grant is made
//           combinationally (round-robin or fixed priority), the result is
//           registered with its owner and held until that owner consumes it.
// Revision: 1.0 - initial release
// ============================================================================
module shift_arbiter #(
    parameter int ROUND_ROBIN = 1
) (
    input  logic           clk,
    input  logic           reset_n,
    shift_arbiter_if.slave bus
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_owner;      // requester whose result is held
    logic        r_last;       // requester granted most recently
    logic [31:0] r_data;
    logic        r_err;

    logic        w_consume;
    logic        w_can_accept;
    logic        w_grant;
    logic        w_accept;
    logic [31:0] w_op_in;
    logic [4:0]  w_op_amount;
    logic        w_op_right;
    logic        w_op_arith;
    logic [31:0] w_shift;
    logic        w_illegal;

    // The held result leaves this cycle when its owner is ready.
    always_comb begin
        w_consume    = (r_state == ST_HOLD) &&
                       (r_owner ? bus.resp1_ready : bus.resp0_ready);
        w_can_accept = (r_state == ST_IDLE) || w_consume;
    end

    // Grant selection; with both valid, round-robin favours the one not granted last.
    always_comb begin
        w_grant = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            w_grant = (ROUND_ROBIN != 0) ? ~r_last : 1'b0;
        end else if (bus.req1_valid) begin
            w_grant = 1'b1;
        end
        w_accept       = w_can_accept && (bus.req0_valid || bus.req1_valid);
        bus.req0_ready = w_accept && !w_grant;
        bus.req1_ready = w_accept &&  w_grant;
    end

    // Operand mux feeding the single shared shifter.
    always_comb begin
        w_op_in     = w_grant ? bus.req1_in     : bus.req0_in;
        w_op_amount = w_grant ? bus.req1_amount : bus.req0_amount;
        w_op_right  = w_grant ? bus.req1_right  : bus.req0_right;
        w_op_arith  = w_grant ? bus.req1_arith  : bus.req0_arith;
    end

    // Shared shifter; arith without right is illegal and falls back to a left shift.
    always_comb begin
        w_illegal = w_op_arith && !w_op_right;
        if (!w_op_right) begin
            w_shift = w_op_in << w_op_amount;
        end else if (w_op_arith) begin
            w_shift = $unsigned($signed(w_op_in) >>> w_op_amount);
        end else begin
            w_shift = w_op_in >> w_op_amount;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state and response valids; a new acceptance always lands in HOLD.
    always_comb begin
        w_state_next    = r_state;
        bus.resp0_valid = 1'b0;
        bus.resp1_valid = 1'b0;
        if (w_accept) begin
            w_state_next = ST_HOLD;
        end else if (w_consume) begin
            w_state_next = ST_IDLE;
        end
        if (r_state == ST_HOLD) begin
            bus.resp0_valid = !r_owner;
            bus.resp1_valid =  r_owner;
        end
    end

    // Result, error flag, owner and arbitration pointer captured on acceptance.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data  <= 32'd0;
            r_err   <= 1'b0;
            r_owner <= 1'b0;
            r_last  <= 1'b1;
        end else if (w_accept) begin
            r_data  <= w_shift;
            r_err   <= w_illegal;
            r_owner <= w_grant;
            r_last  <= w_grant;
        end
    end

    // Registered result is shared by both requesters.
    always_comb begin
        bus.resp_data = r_data;
        bus.resp_err  = r_err;
    end

endmodule
`default_nettype wire

// File: tb/tb_shift_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_shift_arbiter
// Brief   : Directed self-checking bench; a round-robin and a fixed-priority
//           instance share the stimulus, one is checked at a time.
// Revision: 1.0 - initial release
// ============================================================================
module tb_shift_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        sel;          // 0: round-robin DUT, 1: fixed-priority DUT

    logic        req0_valid, req1_valid, resp0_ready, resp1_ready;
    logic [31:0] req0_in, req1_in;
    logic [4:0]  req0_amount, req1_amount;
    logic        req0_right, req0_arith, req1_right, req1_arith;

    int          n_checks = 0;
    int          n_err    = 0;

    typedef struct {
        logic        owner;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    logic        m_last;

    shift_arbiter_if if_rr ();
    shift_arbiter_if if_fp ();

    shift_arbiter #(.ROUND_ROBIN(1)) u_rr (.clk(clk), .reset_n(reset_n), .bus(if_rr));
    shift_arbiter #(.ROUND_ROBIN(0)) u_fp (.clk(clk), .reset_n(reset_n), .bus(if_fp));

    assign if_rr.req0_valid  = req0_valid;   assign if_fp.req0_valid  = req0_valid;
    assign if_rr.req0_in     = req0_in;      assign if_fp.req0_in     = req0_in;
    assign if_rr.req0_amount = req0_amount;  assign if_fp.req0_amount = req0_amount;
    assign if_rr.req0_right  = req0_right;   assign if_fp.req0_right  = req0_right;
    assign if_rr.req0_arith  = req0_arith;   assign if_fp.req0_arith  = req0_arith;
    assign if_rr.req1_valid  = req1_valid;   assign if_fp.req1_valid  = req1_valid;
    assign if_rr.req1_in     = req1_in;      assign if_fp.req1_in     = req1_in;
    assign if_rr.req1_amount = req1_amount;  assign if_fp.req1_amount = req1_amount;
    assign if_rr.req1_right  = req1_right;   assign if_fp.req1_right  = req1_right;
    assign if_rr.req1_arith  = req1_arith;   assign if_fp.req1_arith  = req1_arith;
    assign if_rr.resp0_ready = resp0_ready;  assign if_fp.resp0_ready = resp0_ready;
    assign if_rr.resp1_ready = resp1_ready;  assign if_fp.resp1_ready = resp1_ready;

    logic        o_req0_ready, o_req1_ready, o_resp0_valid, o_resp1_valid, o_resp_err;
    logic [31:0] o_resp_data;
    assign o_req0_ready  = sel ? if_fp.req0_ready  : if_rr.req0_ready;
    assign o_req1_ready  = sel ? if_fp.req1_ready  : if_rr.req1_ready;
    assign o_resp0_valid = sel ? if_fp.resp0_valid : if_rr.resp0_valid;
    assign o_resp1_valid = sel ? if_fp.resp1_valid : if_rr.resp1_valid;
    assign o_resp_data   = sel ? if_fp.resp_data   : if_rr.resp_data;
    assign o_resp_err    = sel ? if_fp.resp_err    : if_rr.resp_err;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference shift computed through a 64-bit window.
    function automatic logic [31:0] ref_shift(input logic [31:0] x, input logic [4:0] a,
                                              input logic r, input logic ar);
        logic [63:0] w;
        if (!r) begin
            w = {32'd0, x} << a;
        end else begin
            w = {{32{ar & x[31]}}, x} >> a;
        end
        return w[31:0];
    endfunction

    // One clock: check outputs at the falling edge, advance the model, pass the rising edge.
    task automatic step();
        logic can_acc, g, e_r0, e_r1, e_v0, e_v1;
        exp_t e;
        @(negedge clk);
        e_v0 = (sb.size() != 0) && !sb[0].owner;
        e_v1 = (sb.size() != 0) &&  sb[0].owner;
        chk("resp0_valid", {31'd0, o_resp0_valid}, {31'd0, e_v0});
        chk("resp1_valid", {31'd0, o_resp1_valid}, {31'd0, e_v1});
        if (sb.size() != 0) begin
            chk("resp_data", o_resp_data, sb[0].data);
            chk("resp_err", {31'd0, o_resp_err}, {31'd0, sb[0].err});
        end
        can_acc = (sb.size() == 0) || (sb[0].owner ? resp1_ready : resp0_ready);
        if (req0_valid && req1_valid) g = sel ? 1'b0 : ~m_last;
        else                          g = req1_valid;
        e_r0 = can_acc && req0_valid && !g;
        e_r1 = can_acc && req1_valid &&  g;
        chk("req0_ready", {31'd0, o_req0_ready}, {31'd0, e_r0});
        chk("req1_ready", {31'd0, o_req1_ready}, {31'd0, e_r1});
        if (sb.size() != 0 && (sb[0].owner ? resp1_ready : resp0_ready)) void'(sb.pop_front());
        if (e_r0 || e_r1) begin
            e.owner = g;
            e.data  = g ? ref_shift(req1_in, req1_amount, req1_right, req1_arith)
                        : ref_shift(req0_in, req0_amount, req0_right, req0_arith);
            e.err   = g ? (req1_arith & ~req1_right) : (req0_arith & ~req0_right);
            sb.push_back(e);
            m_last = g;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        sb.delete();
        m_last = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_resp0_valid", {31'd0, o_resp0_valid}, 32'd0);
        chk("rst_resp1_valid", {31'd0, o_resp1_valid}, 32'd0);
        chk("rst_resp_data", o_resp_data, 32'd0);
        chk("rst_resp_err", {31'd0, o_resp_err}, 32'd0);
        reset_n = 1'b1;
    endtask

    initial begin
        sel = 1'b0;
        req0_valid = 0; req0_in = 0; req0_amount = 0; req0_right = 0; req0_arith = 0;
        req1_valid = 0; req1_in = 0; req1_amount = 0; req1_right = 0; req1_arith = 0;
        resp0_ready = 0; resp1_ready = 0;
        do_reset();

        // Arithmetic right shift of a negative operand, one-cycle latency.
        req0_valid = 1; req0_in = 32'h8000_0001; req0_amount = 5'd4; req0_right = 1; req0_arith = 1;
        resp0_ready = 1;
        step();
        req0_valid = 0;
        chk("t34_latency_valid", {31'd0, o_resp0_valid}, 32'd1);
        chk("t34_data", o_resp_data, 32'hF800_0000);
        step();
        step();

        // req1 left shift held by backpressure; req0 refused meanwhile.
        req1_valid = 1; req1_in = 32'h0000_000F; req1_amount = 5'd31; req1_right = 0; req1_arith = 0;
        resp1_ready = 0;
        step();
        req1_valid = 0;
        req0_valid = 1; req0_in = 32'h1234_5678; req0_amount = 5'd3; req0_right = 0; req0_arith = 0;
        for (int i = 0; i < 3; i++) begin
            req0_in = req0_in + 32'h11;
            step();
        end
        chk("t36_held_data", o_resp_data, 32'h8000_0000);
        req0_valid = 0;
        resp1_ready = 1;
        step();
        step();

        // Contention with round-robin: 0,1,0,1 at one op per cycle.
        resp0_ready = 1; resp1_ready = 1;
        req0_valid = 1; req0_in = 32'hA5A5_0F0F; req0_amount = 5'd8; req0_right = 1; req0_arith = 0;
        req1_valid = 1; req1_in = 32'hF000_0000; req1_amount = 5'd5; req1_right = 1; req1_arith = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t35_resp_owner", {31'd0, o_resp1_valid}, (i % 2 == 0) ? 32'd0 : 32'd1);
        end
        req0_valid = 0; req1_valid = 0;
        step();
        step();

        // Illegal request: arith without right behaves as left shift and flags error.
        req0_valid = 1; req0_in = 32'h1; req0_amount = 5'd1; req0_right = 0; req0_arith = 1;
        step();
        req0_valid = 0;
        chk("t37_data", o_resp_data, 32'h2);
        chk("t37_err", {31'd0, o_resp_err}, 32'd1);
        step();
        step();

        // Asynchronous reset in the middle of a held result.
        req1_valid = 1; req1_in = 32'hDEAD_BEEF; req1_amount = 5'd0; req1_right = 0; req1_arith = 0;
        resp1_ready = 0;
        step();
        req1_valid = 0;
        #1 reset_n = 1'b0;
        #1;
        chk("t38_async_resp1_valid", {31'd0, o_resp1_valid}, 32'd0);
        chk("t38_async_data", o_resp_data, 32'd0);
        sb.delete();
        m_last = 1'b1;
        #1 reset_n = 1'b1;
        req0_valid = 1; req1_valid = 1;
        req0_in = 32'h0000_00F0; req0_amount = 5'd4; req0_right = 1; req0_arith = 0;
        req1_in = 32'h0000_0001; req1_amount = 5'd2; req1_right = 0; req1_arith = 0;
        resp0_ready = 1; resp1_ready = 1;
        step();
        chk("t38_first_grant_req0", {31'd0, o_resp0_valid}, 32'd1);
        step();
        req0_valid = 0; req1_valid = 0;
        step();
        step();

        // Fixed priority instance: req0 wins every cycle.
        sel = 1'b1;
        do_reset();
        req0_valid = 1; req1_valid = 1;
        for (int i = 0; i < 3; i++) begin
            req0_amount = 5'(i + 1);
            step();
            chk("t39_req0_owner", {31'd0, o_resp0_valid}, 32'd1);
        end
        req0_valid = 0;
        step();
        req1_valid = 0;
        step();
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/shift_arbiter.md
SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 The module SHALL have parameter ROUND_ROBIN, default 1, meaning 1 = round-robin grant and 0 = fixed priority with requester 0 highest.
REQ-002 The module SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 The module SHALL have port req0_valid, input, 1, requester 0 operation valid.
REQ-005 The module SHALL have port req0_ready, output, 1, requester 0 operation accepted this cycle when high with req0_valid.
REQ-006 The module SHALL have ports req0_in (input, 32, operand), req0_amount (input, 5, shift amount), req0_right (input, 1, right shift) and req0_arith (input, 1, arithmetic right shift).
REQ-007 The module SHALL have ports req1_valid, req1_ready, req1_in, req1_amount, req1_right and req1_arith, identical to REQ-004..006 for requester 1.
REQ-008 The module SHALL have ports resp0_valid and resp1_valid, output, 1 each, result pending for that requester.
REQ-009 The module SHALL have ports resp0_ready and resp1_ready, input, 1 each, requester consumes its result.
REQ-010 The module SHALL have port resp_data, output, 32, registered shift result, shared by both requesters.
REQ-011 The module SHALL have port resp_err, output, 1, registered flag marking that the held result came from an illegal request.

Function
REQ-012 The module SHALL instantiate exactly one shifter datapath, shared by both requesters.
REQ-013 The shifter datapath SHALL compute a 32-bit left logical, right logical or right arithmetic shift of the operand, with the 5-bit amount selecting a shift of 0..31.
REQ-014 The module SHALL have a two-state FSM: IDLE (no result held) and HOLD (result held in resp_data/resp_err with owner ID).
REQ-015 The grant SHALL be computed combinationally each cycle that the module can accept, among the requesters with valid high.
REQ-016 With ROUND_ROBIN=1 and both requesters valid, the grant SHALL go to the requester not granted last; with one valid, that one wins.
REQ-017 With ROUND_ROBIN=0, req0 SHALL always win over req1.
REQ-018 reqN_ready SHALL be high only for the granted requester, and only when state is IDLE, or state is HOLD and the owner's respN_ready is high this cycle.
REQ-019 reqN_ready SHALL never be high for a requester whose valid is low.
REQ-020 On acceptance, the shifter result, the error flag and the owner SHALL be registered on the same edge, and state SHALL become HOLD.
REQ-021 Latency SHALL be 1 cycle: the request is accepted in cycle N and respN_valid is high in cycle N+1.
REQ-022 In HOLD, respN_valid SHALL be high only for the owner, and resp_data and resp_err SHALL be held stable until the owner's respN_ready is high.
REQ-023 A response consumed without a new acceptance in the same cycle SHALL return the FSM to IDLE.
REQ-024 A response consumed with a new acceptance in the same cycle SHALL keep the FSM in HOLD with the new result and owner; sustained throughput SHALL be 1 op/cycle.
REQ-025 respN_ready from a non-owner, or asserted in IDLE, SHALL be ignored.
REQ-026 The round-robin pointer SHALL update only on acceptance, and never on cycles where a request is refused.
REQ-027 A request with arith=1 and right=0 SHALL be illegal: it SHALL be accepted and shifted as a logical left, with resp_err=1.
REQ-028 Requester inputs SHALL be sampled only on the acceptance edge; changes while ready is low SHALL have no effect.

Reset
REQ-029 Assertion of reset_n low SHALL immediately, without waiting for clk, force state to IDLE.
REQ-030 Reset SHALL force resp0_valid=0, resp1_valid=0, resp_data=0, resp_err=0, and the owner register to 0.
REQ-031 Reset SHALL set the round-robin pointer to "last granted = 1", so req0 wins the first contention.
REQ-032 Reset during HOLD SHALL discard the held result with no response delivered.
REQ-033 Release of reset_n SHALL be sampled synchronously; the first acceptance SHALL be possible on the first rising edge after release.

Verification
REQ-034 Directed test: req0 with in=0x80000001, amount=4, right=1, arith=1 and resp0_ready=1 -> resp0_valid next cycle, resp_data=0xF8000000, resp_err=0.
REQ-035 Directed test: both requesters valid for 4 cycles with ROUND_ROBIN=1 and resp ready high -> grants alternate 0,1,0,1, with one response per cycle.
REQ-036 Directed test: req1 with in=0x0000000F, amount=31, right=0, resp1_ready=0 for 3 cycles -> resp_data=0x80000000 held stable, req0_ready=req1_ready=0 throughout, and release on the 4th cycle.
REQ-037 Directed test: illegal req0 with in=0x1, amount=1, right=0, arith=1 -> resp_data=0x2, resp_err=1.
REQ-038 Directed test: reset_n pulsed low mid-HOLD between clock edges -> resp valids drop immediately, and after release simultaneous req0/req1 grant req0 first.
REQ-039 Directed test: ROUND_ROBIN=0 with both requesters valid for 3 cycles -> req0 is granted every cycle and req1_ready stays 0.
